// File: rtl/sandpile_pixel_renderer.sv
// Sandpile grid renderer: maps raw VGA counters to grid-cell reads and palettes
// the 2-bit cell value to RGB444, four edges behind the coordinates.
module sandpile_pixel_renderer #(
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int CELL_SHIFT = 3,
  parameter int GRID_W     = 80,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [1:0]        mem_rdata,
  input  logic              pal_we,
  input  logic [1:0]        pal_idx,
  input  logic [11:0]       pal_wdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              frame_tick
);

  localparam int         STAGES = 4;
  localparam logic [9:0] HD     = 10'(H_DISPLAY);
  localparam logic [9:0] VD     = 10'(V_DISPLAY);
  localparam logic [9:0] HT_END = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_END = 10'(V_TOTAL - 1);

  logic              active0;
  logic [ADDR_W-1:0] row0, col0, addr0;
  logic [STAGES-1:1] vld_pipe;
  logic [1:0]        idx3;
  logic [11:0]       pal [4];

  // Out-of-range counters fall outside the visible window, so they blank too.
  always_comb begin
    active0 = (pixel_x < HD) && (pixel_y < VD);
    row0    = ADDR_W'(pixel_y >> CELL_SHIFT);
    col0    = ADDR_W'(pixel_x >> CELL_SHIFT);
    addr0   = active0 ? (row0 * ADDR_W'(GRID_W) + col0) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      vld_pipe   <= '0;
      idx3       <= '0;
      {red, green, blue} <= 12'h000;
      frame_tick <= 1'b0;
    end else begin
      mem_addr   <= addr0;
      mem_re     <= active0;
      vld_pipe   <= {vld_pipe[STAGES-2:1], active0};
      idx3       <= vld_pipe[2] ? mem_rdata : 2'd0;
      // Palette read sees the pre-write value when a write lands on this edge.
      {red, green, blue} <= vld_pipe[3] ? pal[idx3] : 12'h000;
      frame_tick <= (pixel_x == HT_END) && (pixel_y == VT_END);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pal[0] <= 12'h000;
      pal[1] <= 12'h00F;
      pal[2] <= 12'h0F0;
      pal[3] <= 12'hF00;
    end else if (pal_we) begin
      pal[pal_idx] <= pal_wdata;
    end
  end

endmodule

// File: tb/tb_sandpile_pixel_renderer.sv
// Directed bench for sandpile_pixel_renderer with a synchronous grid-memory
// model returning (addr mod 4).
module tb_sandpile_pixel_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic [12:0] mem_addr;
  logic        mem_re;
  logic [1:0]  mem_rdata = 2'd0;
  logic        pal_we;
  logic [1:0]  pal_idx;
  logic [11:0] pal_wdata;
  logic [3:0]  red, green, blue;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  sandpile_pixel_renderer dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_wdata(pal_wdata),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Synchronous-read grid memory: data valid the cycle after the address.
  always @(posedge clk) if (mem_re) mem_rdata <= mem_addr[1:0];

  typedef struct {
    int          x;
    int          y;
    int          addr;
    bit          re;
    logic [11:0] rgb;
    bit          tick;
  } vec_t;

  vec_t        vecs[14];
  logic [11:0] pal_m[4] = '{12'h000, 12'h00F, 12'h0F0, 12'hF00};

  function automatic logic [11:0] model_rgb(int x, int y);
    if (x < 640 && y < 480) return pal_m[((y / 8) * 80 + x / 8) % 4];
    return 12'h000;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_xy(int x, int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  function automatic int rgb();
    return int'({red, green, blue});
  endfunction

  initial begin
    int re_cnt, tick_cnt, line_err;
    logic [11:0] exp_q[$];
    logic [11:0] e;

    vecs[0]  = '{0,    0,    0,    1, 12'h000, 0};
    vecs[1]  = '{8,    0,    1,    1, 12'h00F, 0};
    vecs[2]  = '{0,    8,    80,   1, 12'h000, 0};
    vecs[3]  = '{639,  479,  4799, 1, 12'hF00, 0};
    vecs[4]  = '{16,   0,    2,    1, 12'h0F0, 0};
    vecs[5]  = '{24,   8,    83,   1, 12'hF00, 0};
    vecs[6]  = '{13,   17,   161,  1, 12'h00F, 0};
    vecs[7]  = '{328,  240,  2441, 1, 12'h00F, 0};
    vecs[8]  = '{640,  0,    0,    0, 12'h000, 0};
    vecs[9]  = '{0,    480,  0,    0, 12'h000, 0};
    vecs[10] = '{799,  524,  0,    0, 12'h000, 1};
    vecs[11] = '{800,  524,  0,    0, 12'h000, 0};
    vecs[12] = '{1023, 1023, 0,    0, 12'h000, 0};
    vecs[13] = '{7,    7,    0,    1, 12'h000, 0};

    reset_n = 1'b0; pal_we = 1'b0; pal_idx = 2'd0; pal_wdata = 12'h000;
    set_xy(8, 0);
    step(); step();
    chk("reset mem_addr", int'(mem_addr), 0);
    chk("reset mem_re", int'(mem_re), 0);
    chk("reset rgb", rgb(), 0);
    chk("reset frame_tick", int'(frame_tick), 0);
    reset_n = 1'b1;

    // Each vector held for four edges: address after one, colour after four.
    foreach (vecs[i]) begin
      set_xy(vecs[i].x, vecs[i].y);
      step();
      chk($sformatf("v%0d mem_addr", i), int'(mem_addr), vecs[i].addr);
      chk($sformatf("v%0d mem_re", i), int'(mem_re), int'(vecs[i].re));
      chk($sformatf("v%0d frame_tick", i), int'(frame_tick), int'(vecs[i].tick));
      step(); step(); step();
      chk($sformatf("v%0d rgb", i), rgb(), int'(vecs[i].rgb));
    end

    // Single active pixel between blanks: one coloured cycle, four edges later.
    set_xy(640, 0);
    repeat (4) step();
    set_xy(8, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        chk("lat mem_re on", int'(mem_re), 1);
        set_xy(640, 0);
      end
      if (k == 2) chk("lat mem_re off", int'(mem_re), 0);
      chk($sformatf("lat rgb k%0d", k), rgb(), (k == 4) ? 12'h00F : 12'h000);
    end

    // Full line sweep: 640 reads, no ticks, colour tracks the model.
    re_cnt = 0; tick_cnt = 0; line_err = 0;
    for (int x = 0; x < 804; x++) begin
      if (x < 800) set_xy(x, 8); else set_xy(x - 800, 9);
      exp_q.push_back(model_rgb(int'(pixel_x), int'(pixel_y)));
      step();
      if (x < 800 && mem_re) re_cnt++;
      if (frame_tick) tick_cnt++;
      if (exp_q.size() == 4) begin
        e = exp_q.pop_front();
        if (rgb() != int'(e)) line_err++;
      end
    end
    chk("line mem_re count", re_cnt, 640);
    chk("line frame_tick count", tick_cnt, 0);
    chk("line rgb errors", line_err, 0);

    // frame_tick: end-of-frame then wrap.
    set_xy(798, 524); step();
    chk("tick before end", int'(frame_tick), 0);
    set_xy(799, 524); step();
    chk("tick at end", int'(frame_tick), 1);
    set_xy(0, 0); step();
    chk("tick after wrap", int'(frame_tick), 0);

    // Palette write while rendering cell-2 pixels.
    set_xy(16, 0);
    repeat (4) step();
    chk("pal pre", rgb(), 12'h0F0);
    pal_we = 1'b1; pal_idx = 2'd2; pal_wdata = 12'hABC;
    step();
    pal_we = 1'b0;
    chk("pal same edge old", rgb(), 12'h0F0);
    step();
    chk("pal next edge new", rgb(), 12'hABC);

    // Mid-line reset flushes pipeline and restores the palette.
    reset_n = 1'b0;
    step();
    chk("mid rst rgb", rgb(), 0);
    chk("mid rst mem_re", int'(mem_re), 0);
    chk("mid rst mem_addr", int'(mem_addr), 0);
    step();
    chk("mid rst rgb 2", rgb(), 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("post rst rgb k%0d", k), rgb(), (k == 4) ? 12'h0F0 : 12'h000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
